// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, SR/Cause field positions
// and handler address defaults.
package cp0_exc_unit_pkg;

  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_SR       = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;
  localparam logic [4:0] CP0_REG_PRID     = 5'd15;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int unsigned SR_IE_BIT     = 0;
  localparam int unsigned SR_EXL_BIT    = 1;
  localparam int unsigned SR_IM_LSB     = 10;
  localparam int unsigned SR_IM_MSB     = 15;
  localparam int unsigned CAUSE_EXC_LSB = 2;
  localparam int unsigned CAUSE_EXC_MSB = 6;
  localparam int unsigned CAUSE_IP_LSB  = 10;
  localparam int unsigned CAUSE_IP_MSB  = 15;
  localparam int unsigned CAUSE_BD_BIT  = 31;

  localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_4180;
  localparam logic [31:0] PRID_DEFAULT         = 32'h0000_0018;

  function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
    logic [31:0] pc_al;
    pc_al = pc & ~32'd3;
    return bd ? (pc_al - 32'd4) : pc_al;
  endfunction

  function automatic logic exc_is_addr(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_exc_unit_req_arb.sv
// Combinational interrupt/exception request arbitration; interrupts win over
// a simultaneous pipeline exception and report ExcCode 0.
module cp0_req_arb
  import cp0_exc_unit_pkg::*;
(
  input  logic       ie,
  input  logic       exl,
  input  logic [5:0] im,
  input  logic [5:0] hwint,
  input  logic [4:0] exccode_m,
  output logic       int_req,
  output logic       exc_req,
  output logic [4:0] exc_code
);

  always_comb begin
    int_req  = ie & ~exl & (|(hwint & im));
    exc_req  = ~exl & (exccode_m != EXC_NONE);
    exc_code = int_req ? EXC_INT : exccode_m;
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt controller at the M stage: SR/Cause/EPC/PRId, mfc0/mtc0/eret.
// Optional BadVAddr (reg 8) and vaddr_m port under `define CP0_BADVADDR_EN.
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT,
  parameter logic [31:0] PRID_VAL     = PRID_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic [4:0]  exccode_m,
  input  logic        bd_m,
  input  logic [5:0]  hwint,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0] vaddr_m,
`endif
  input  logic [4:0]  rd_addr,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        we,
  input  logic        eret_m,
  output logic [31:0] rd_data,
  output logic [31:0] epc,
  output logic        req,
  output logic [31:0] handler_pc
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_rd;

  logic        int_req;
  logic        exc_req;
  logic [4:0]  exc_code;

  cp0_req_arb u_req_arb (
    .ie        (sr_ie),
    .exl       (sr_exl),
    .im        (sr_im),
    .hwint     (hwint),
    .exccode_m (exccode_m),
    .int_req   (int_req),
    .exc_req   (exc_req),
    .exc_code  (exc_code)
  );

  // exccode_m is not masked by reset state, so reset must gate the request directly.
  always_comb begin
    req        = (int_req | exc_req) & ~reset;
    epc        = epc_q;
    handler_pc = HANDLER_ADDR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc_q     <= '0;
    end else begin
      cause_ip <= hwint;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_exc <= exc_code;
        cause_bd  <= bd_m;
        epc_q     <= epc_target(pc_m, bd_m);
      end else begin
        if (we) begin
          case (wr_addr)
            CP0_REG_SR: begin
              sr_im  <= wr_data[SR_IM_MSB:SR_IM_LSB];
              sr_exl <= wr_data[SR_EXL_BIT];
              sr_ie  <= wr_data[SR_IE_BIT];
            end
            CP0_REG_EPC: epc_q <= wr_data & ~32'd3;
            default: ;
          endcase
        end
        // Placed after the mtc0 so eret clears EXL over a same-cycle SR write.
        if (eret_m) sr_exl <= 1'b0;
      end
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      badvaddr_q <= '0;
    end else if (req && !int_req && exc_is_addr(exccode_m)) begin
      badvaddr_q <= vaddr_m;
    end
  end

  always_comb badvaddr_rd = badvaddr_q;
`else
  always_comb badvaddr_rd = '0;
`endif

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      CP0_REG_BADVADDR: rd_data = badvaddr_rd;
      CP0_REG_SR: begin
        rd_data[SR_IM_MSB:SR_IM_LSB] = sr_im;
        rd_data[SR_EXL_BIT]          = sr_exl;
        rd_data[SR_IE_BIT]           = sr_ie;
      end
      CP0_REG_CAUSE: begin
        rd_data[CAUSE_BD_BIT]                = cause_bd;
        rd_data[CAUSE_IP_MSB:CAUSE_IP_LSB]   = cause_ip;
        rd_data[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = cause_exc;
      end
      CP0_REG_EPC:  rd_data = epc_q;
      CP0_REG_PRID: rd_data = PRID_VAL;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Scoreboard bench for cp0_exc_unit; expectations queued with stimulus, drained against DUT.
`timescale 1ns/1ps
module tb_cp0_exc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_m;
  logic [4:0]  exccode_m;
  logic        bd_m;
  logic [5:0]  hwint;
  logic [31:0] vaddr_m;
  logic [4:0]  rd_addr;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        we;
  logic        eret_m;
  logic [31:0] rd_data;
  logic [31:0] epc;
  logic        req;
  logic [31:0] handler_pc;

  always #50 clk = ~clk;

  cp0_exc_unit #(
    .HANDLER_ADDR (32'h0000_4180),
    .PRID_VAL     (32'h0000_0018)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_m       (pc_m),
    .exccode_m  (exccode_m),
    .bd_m       (bd_m),
    .hwint      (hwint),
`ifdef CP0_BADVADDR_EN
    .vaddr_m    (vaddr_m),
`endif
    .rd_addr    (rd_addr),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .we         (we),
    .eret_m     (eret_m),
    .rd_data    (rd_data),
    .epc        (epc),
    .req        (req),
    .handler_pc (handler_pc)
  );

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [31:0] exp;
  } exp_t;

  localparam int unsigned SEL_REQ = 32;
  localparam int unsigned SEL_EPC = 33;
  localparam int unsigned SEL_HPC = 34;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int unsigned sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel < 32) rd_addr = e.sel[4:0];
      #1;
      case (e.sel)
        SEL_REQ: got = {31'd0, req};
        SEL_EPC: got = epc;
        SEL_HPC: got = handler_pc;
        default: got = rd_data;
      endcase
      check_eq(e.tag, got, e.exp);
    end
  endtask

  task automatic idle();
    exccode_m = 5'd0;
    bd_m      = 1'b0;
    we        = 1'b0;
    wr_addr   = 5'd0;
    wr_data   = 32'd0;
    eret_m    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=%0t exp=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    reset = 1'b1;
    pc_m = 32'd0; vaddr_m = 32'd0; rd_addr = 5'd0;
    hwint = 6'h3F;
    exccode_m = 5'd10;
    #20;
    expect_val("req_during_reset", SEL_REQ, 32'd0);
    drain();

    @(negedge clk);
    reset = 1'b0;
    exccode_m = 5'd0;
    expect_val("rst_sr", 12, 32'd0);
    expect_val("rst_cause", 13, 32'd0);
    expect_val("rst_epc", 14, 32'd0);
    expect_val("rst_prid", 15, 32'h0000_0018);
    expect_val("rst_badvaddr", 8, 32'd0);
    expect_val("rst_other", 3, 32'd0);
    expect_val("rst_req_ie0", SEL_REQ, 32'd0);
    expect_val("handler_pc", SEL_HPC, 32'h0000_4180);
    drain();
    hwint = 6'h00;
    step();

    // Reserved instruction, not in delay slot
    exccode_m = 5'd10; pc_m = 32'h0000_3008;
    expect_val("ri_req", SEL_REQ, 32'd1);
    drain();
    step();
    expect_val("ri_epc", 14, 32'h0000_3008);
    expect_val("ri_cause", 13, 32'h0000_0028);
    expect_val("ri_sr_exl", 12, 32'h0000_0002);
    expect_val("ri_epc_port", SEL_EPC, 32'h0000_3008);
    expect_val("ri_req_after", SEL_REQ, 32'd0);
    drain();

    eret_m = 1'b1;
    step();
    expect_val("eret_clr", 12, 32'd0);
    drain();

    // Overflow in delay slot, then a masked nested exception
    exccode_m = 5'd12; bd_m = 1'b1; pc_m = 32'h0000_3010;
    expect_val("ov_req", SEL_REQ, 32'd1);
    drain();
    step();
    expect_val("ov_epc_bd", 14, 32'h0000_300C);
    expect_val("ov_cause_bd", 13, 32'h8000_0030);
    drain();
    exccode_m = 5'd4; pc_m = 32'h0000_3020;
    expect_val("nested_masked", SEL_REQ, 32'd0);
    drain();
    step();
    expect_val("nested_epc_hold", 14, 32'h0000_300C);
    expect_val("nested_cause_hold", 13, 32'h8000_0030);
    drain();

    eret_m = 1'b1;
    step();
    we = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_FC01;
    expect_val("mtc0_sr_req0", SEL_REQ, 32'd0);
    drain();
    step();
    expect_val("mtc0_sr", 12, 32'h0000_FC01);
    drain();

    // Interrupt beats a simultaneous AdES
    hwint = 6'h04; exccode_m = 5'd5; pc_m = 32'h0000_3040;
    expect_val("int_req", SEL_REQ, 32'd1);
    drain();
    step();
    hwint = 6'h00;
    expect_val("int_cause", 13, 32'h0000_1000);
    expect_val("int_sr", 12, 32'h0000_FC03);
    expect_val("int_epc", 14, 32'h0000_3040);
    drain();

    eret_m = 1'b1;
    step();
    expect_val("eret_exl0", 12, 32'h0000_FC01);
    drain();

    eret_m = 1'b1; exccode_m = 5'd10; pc_m = 32'h0000_3050;
    expect_val("eret_vs_exc_req", SEL_REQ, 32'd1);
    drain();
    step();
    expect_val("eret_vs_exc_sr", 12, 32'h0000_FC03);
    expect_val("eret_vs_exc_epc", 14, 32'h0000_3050);
    drain();

    eret_m = 1'b1;
    step();
    exccode_m = 5'd10; pc_m = 32'h0000_3060;
    we = 1'b1; wr_addr = 5'd14; wr_data = 32'h0000_3017;
    expect_val("drop_req", SEL_REQ, 32'd1);
    drain();
    step();
    expect_val("mtc0_dropped", 14, 32'h0000_3060);
    drain();

    eret_m = 1'b1;
    step();
    we = 1'b1; wr_addr = 5'd14; wr_data = 32'h0000_3017;
    expect_val("epc_no_bypass", 14, 32'h0000_3060);
    drain();
    step();
    expect_val("mtc0_epc", 14, 32'h0000_3014);
    expect_val("mtc0_epc_port", SEL_EPC, 32'h0000_3014);
    drain();

    we = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_0403; eret_m = 1'b1;
    step();
    expect_val("sr_then_eret", 12, 32'h0000_0401);
    drain();

    we = 1'b1; wr_addr = 5'd13; wr_data = 32'hFFFF_FFFF;
    step();
    expect_val("cause_ro", 13, 32'h0000_0028);
    drain();

    // AdEL with a bad address
    exccode_m = 5'd4; pc_m = 32'h0000_3070; vaddr_m = 32'h0000_0003;
    expect_val("adel_req", SEL_REQ, 32'd1);
    drain();
    step();
    expect_val("adel_cause", 13, 32'h0000_0010);
    expect_val("adel_epc", 14, 32'h0000_3070);
`ifdef CP0_BADVADDR_EN
    expect_val("badvaddr", 8, 32'h0000_0003);
`else
    expect_val("badvaddr_absent", 8, 32'd0);
`endif
    drain();

    // Asynchronous reset while the handler runs
    hwint = 6'h3F;
    #10;
    reset = 1'b1;
    expect_val("midrst_sr", 12, 32'd0);
    expect_val("midrst_epc", 14, 32'd0);
    expect_val("midrst_req", SEL_REQ, 32'd0);
    drain();
    @(negedge clk);
    reset = 1'b0;
    expect_val("postrst_req", SEL_REQ, 32'd0);
    drain();
    step();
    expect_val("postrst_req2", SEL_REQ, 32'd0);
    expect_val("postrst_ip", 13, 32'h0000_FC00);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
